// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared types and defaults for the FFT frame sequencer
package fft_ctrl_pkg;

    localparam int BUF_AW_DEF    = 10;
    localparam int FRAME_LEN_DEF = 256;
    localparam int DW_DEF        = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [BUF_AW_DEF-1:0] base;
        logic [BUF_AW_DEF-1:0] hop;
        logic [7:0]            frames;
        logic                  win;
        logic [7:0]            n_need;
        logic [3:0]            scale;
    } cfg_t;

    // A frame count of zero still runs one frame.
    function automatic logic [7:0] frames_eff(input logic [7:0] frames);
        return (frames == 8'd0) ? 8'd1 : frames;
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// rtl/fft_frame_ctrl_if.sv - sample RAM, pipeline input/result and forwarded result signals
interface fft_frame_ctrl_if #(
    parameter int BUF_AW = fft_ctrl_pkg::BUF_AW_DEF,
    parameter int DW     = fft_ctrl_pkg::DW_DEF
);
    logic              smp_rd_en;
    logic [BUF_AW-1:0] smp_addr;
    logic [DW-1:0]     smp_rdata;

    logic [DW-1:0]     fft_data;
    logic              fft_valid;
    logic              fft_ready;
    logic              fft_win;
    logic [7:0]        fft_n_need;
    logic [3:0]        fft_scale;

    logic [DW-1:0]     res_data;
    logic              res_valid;
    logic              res_last;
    logic              res_ready;

    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport master (
        output smp_rd_en, smp_addr,
        input  smp_rdata,
        output fft_data, fft_valid, fft_win, fft_n_need, fft_scale,
        input  fft_ready,
        input  res_data, res_valid, res_last,
        output res_ready,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  smp_rd_en, smp_addr,
        output smp_rdata,
        input  fft_data, fft_valid, fft_win, fft_n_need, fft_scale,
        output fft_ready,
        output res_data, res_valid, res_last,
        input  res_ready,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_skid_fifo2.sv
// rtl/fft_skid_fifo2.sv - 2-entry FIFO absorbing the one-cycle RAM read latency
module fft_skid_fifo2
    import fft_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic [1:0]    o_count
);
    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    // Caller never pushes when full nor pops when empty; flush overrides both.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame sequencer feeding the window/FFT pipeline from a circular sample RAM
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int BUF_AW    = BUF_AW_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic              i_hclk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [BUF_AW-1:0] i_cfg_base,
    input  logic [BUF_AW-1:0] i_cfg_hop,
    input  logic [7:0]        i_cfg_frames,
    input  logic              i_cfg_win,
    input  logic [7:0]        i_cfg_n_need,
    input  logic [3:0]        i_cfg_scale,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [7:0]        o_frame_idx,
    fft_frame_ctrl_if.master  m_if
);
    localparam int            CW    = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LEN_C = CW'(FRAME_LEN);

    state_t        r_state, w_state_nxt;
    cfg_t          r_cfg;
    logic [CW-1:0] r_issued;
    logic [CW-1:0] r_accepted;
    logic          r_inflight;
    logic [7:0]    r_frame_idx;
    logic [15:0]   r_beats;
    logic          r_done;
    logic          r_err;

    logic [DW-1:0] w_head;
    logic [1:0]    w_fifo_count;
    logic [1:0]    w_occ;
    logic          w_busy;
    logic          w_pop;
    logic          w_rd_en;
    logic          w_res_ready;
    logic          w_res_acc;
    logic          w_close;
    logic          w_frames_left;
    logic [15:0]   w_beats_inc;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_pop       = (w_fifo_count != 2'd0) && m_if.fft_ready;
    // Slots freed by this cycle's pop are reusable at once, keeping 1 sample/cycle.
    assign w_occ       = w_fifo_count - {1'b0, w_pop} + {1'b0, r_inflight};
    assign w_rd_en     = (r_state == ST_FEED) && (w_occ < 2'd2) && (r_issued < LEN_C);
    assign w_res_ready = m_if.out_ready && w_busy;
    assign w_res_acc   = m_if.res_valid && w_res_ready;
    assign w_close     = w_res_acc && m_if.res_last;
    assign w_beats_inc = r_beats + 16'd1;
    assign w_frames_left = ({1'b0, r_frame_idx} + 9'd1) < {1'b0, frames_eff(r_cfg.frames)};

    fft_skid_fifo2 #(.DW(DW)) u_skid (
        .i_clk       (i_hclk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_abort),
        .i_push      (r_inflight),
        .i_push_data (m_if.smp_rdata),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_FEED;
            ST_FEED:  if (w_pop && (r_accepted == LEN_C - CW'(1))) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_close) w_state_nxt = w_frames_left ? ST_NEXT : ST_DONE;
            ST_NEXT:  w_state_nxt = ST_FEED;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (i_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_hclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cfg       <= '0;
            r_issued    <= '0;
            r_accepted  <= '0;
            r_inflight  <= 1'b0;
            r_frame_idx <= 8'd0;
            r_beats     <= 16'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // A read issued in the abort cycle must not land in the flushed FIFO.
            r_inflight <= w_rd_en && !i_abort;
            if (i_abort) begin
                r_issued   <= '0;
                r_accepted <= '0;
                r_beats    <= 16'd0;
            end else begin
                case (r_state)
                    ST_IDLE: if (i_start) begin
                        r_cfg       <= '{base:   BUF_AW_DEF'(i_cfg_base),
                                         hop:    BUF_AW_DEF'(i_cfg_hop),
                                         frames: i_cfg_frames,
                                         win:    i_cfg_win,
                                         n_need: i_cfg_n_need,
                                         scale:  i_cfg_scale};
                        r_frame_idx <= 8'd0;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_issued    <= '0;
                        r_accepted  <= '0;
                        r_beats     <= 16'd0;
                    end
                    ST_NEXT: begin
                        r_cfg.base  <= r_cfg.base + r_cfg.hop;
                        r_frame_idx <= r_frame_idx + 8'd1;
                        r_issued    <= '0;
                        r_accepted  <= '0;
                    end
                    ST_DONE: r_done <= 1'b1;
                    default: ;
                endcase
                if (w_rd_en) r_issued <= r_issued + CW'(1);
                if (w_pop && (r_state == ST_FEED)) r_accepted <= r_accepted + CW'(1);
                if (w_res_acc) begin
                    if (m_if.res_last) begin
                        r_beats <= 16'd0;
                        // A last while samples are still being fed is always an error.
                        if ((r_state == ST_FEED) || (w_beats_inc != {8'd0, r_cfg.n_need}))
                            r_err <= 1'b1;
                    end else begin
                        r_beats <= w_beats_inc;
                    end
                end
            end
        end
    end

    assign m_if.smp_rd_en  = w_rd_en;
    assign m_if.smp_addr   = BUF_AW'(r_cfg.base) + BUF_AW'(r_issued);
    assign m_if.fft_data   = w_head;
    assign m_if.fft_valid  = (w_fifo_count != 2'd0);
    assign m_if.fft_win    = r_cfg.win;
    assign m_if.fft_n_need = r_cfg.n_need;
    assign m_if.fft_scale  = r_cfg.scale;
    assign m_if.res_ready  = w_res_ready;
    assign m_if.out_data   = m_if.res_data;
    assign m_if.out_valid  = m_if.res_valid && w_busy;
    assign m_if.out_last   = m_if.res_last;

    assign o_busy      = w_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_frame_idx = r_frame_idx;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed self-checking bench for fft_frame_ctrl
module tb_fft_frame_ctrl;
    import fft_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] cfg_base = '0;
    logic [9:0] cfg_hop = '0;
    logic [7:0] cfg_frames = '0;
    logic       cfg_win = 1'b0;
    logic [7:0] cfg_n_need = '0;
    logic [3:0] cfg_scale = '0;
    logic       busy, done, err;
    logic [7:0] frame_idx;

    logic rnd_mode = 1'b0;
    logic rnd_fft = 1'b1, rnd_out = 1'b1;
    logic fix_fft_ready = 1'b1, fix_out_ready = 1'b1;
    int   emit_n = 128;

    int n_checks = 0;
    int n_fail = 0;

    logic [9:0]  rd_addr_q[$];
    logic [7:0]  rd_fidx_q[$];
    logic [31:0] fed_q[$];
    logic [31:0] out_q[$];
    int          out_last_cnt = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    int fed_cnt = 0;
    int to_emit = 0;
    int emit_seq = 0;

    always #5 clk = ~clk;

    fft_frame_ctrl_if #(.BUF_AW(10), .DW(32)) bus ();

    fft_frame_ctrl dut (
        .i_hclk       (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_cfg_base   (cfg_base),
        .i_cfg_hop    (cfg_hop),
        .i_cfg_frames (cfg_frames),
        .i_cfg_win    (cfg_win),
        .i_cfg_n_need (cfg_n_need),
        .i_cfg_scale  (cfg_scale),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_frame_idx  (frame_idx),
        .m_if         (bus)
    );

    function automatic logic [31:0] ram_val(input int a);
        return 32'h5A00_0000 + (32'(a) * 32'h0001_0003);
    endfunction

    assign bus.fft_ready = rnd_mode ? rnd_fft : fix_fft_ready;
    assign bus.out_ready = rnd_mode ? rnd_out : fix_out_ready;

    always @(negedge clk) begin
        rnd_fft = ($urandom_range(0, 1) == 0);
        rnd_out = ($urandom_range(0, 9) < 3);
    end

    // Sample RAM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.smp_rd_en) bus.smp_rdata <= ram_val(int'(bus.smp_addr));
        else               bus.smp_rdata <= 32'hDEAD_BEEF;
    end

    // Pipeline model: after each 256 fed samples, emit emit_n result beats, the final one with last.
    always @(posedge clk) begin
        if (!rst_n || !busy) begin
            fed_cnt = 0;
            to_emit = 0;
            emit_seq = 0;
            bus.res_valid <= 1'b0;
            bus.res_last  <= 1'b0;
            bus.res_data  <= '0;
        end else begin
            if (bus.res_valid && bus.res_ready) begin
                to_emit--;
                emit_seq++;
            end
            if (bus.fft_valid && bus.fft_ready) begin
                fed_cnt++;
                if (fed_cnt == 256) begin
                    fed_cnt = 0;
                    to_emit += emit_n;
                end
            end
            bus.res_valid <= (to_emit > 0);
            bus.res_last  <= (to_emit == 1);
            bus.res_data  <= 32'hE000_0000 + 32'(emit_seq);
        end
    end

    // Monitor: record reads, fed samples, forwarded results and stall stability.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.smp_rd_en) begin
                rd_addr_q.push_back(bus.smp_addr);
                rd_fidx_q.push_back(frame_idx);
            end
            if (bus.fft_valid && bus.fft_ready) fed_q.push_back(bus.fft_data);
            if (bus.out_valid && bus.out_ready) begin
                out_q.push_back(bus.out_data);
                if (bus.out_last) out_last_cnt++;
            end
            if (prev_stall && (!bus.fft_valid || bus.fft_data !== prev_data)) stall_viol++;
            prev_stall = bus.fft_valid && !bus.fft_ready;
            prev_data  = bus.fft_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_start(input logic [9:0] base, input logic [9:0] hop, input logic [7:0] frames,
                            input logic [7:0] n_need, input logic win, input logic [3:0] scale);
        cfg_base = base; cfg_hop = hop; cfg_frames = frames;
        cfg_n_need = n_need; cfg_win = win; cfg_scale = scale;
        rd_addr_q.delete(); rd_fidx_q.delete(); fed_q.delete(); out_q.delete();
        out_last_cnt = 0;
        stall_viol = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_status: busy=%0b done=%0b err=%0b want 000", busy, done, err); end
        n_checks++; if (frame_idx !== 8'd0) begin n_fail++; $display("FAIL reset_frame_idx: got %0d want 0", frame_idx); end
        n_checks++; if (bus.smp_rd_en !== 1'b0 || bus.smp_addr !== 10'd0) begin n_fail++; $display("FAIL reset_smp: rd_en=%0b addr=%0d want 0 0", bus.smp_rd_en, bus.smp_addr); end
        n_checks++; if (bus.fft_valid !== 1'b0 || bus.fft_data !== 32'd0) begin n_fail++; $display("FAIL reset_fft: valid=%0b data=%0h want 0 0", bus.fft_valid, bus.fft_data); end
        n_checks++; if (bus.res_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res: res_ready=%0b out_valid=%0b want 0 0", bus.res_ready, bus.out_valid); end
        n_checks++; if ({bus.fft_win, bus.fft_n_need, bus.fft_scale} !== 13'd0) begin n_fail++; $display("FAIL reset_ctrl: win=%0b n_need=%0d scale=%0d want 0", bus.fft_win, bus.fft_n_need, bus.fft_scale); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame;
        bit to;
        emit_n = 128;
        do_start(10'd0, 10'd256, 8'd1, 8'd128, 1'b1, 4'h5);
        n_checks++; if (busy !== 1'b1 || bus.smp_rd_en !== 1'b1 || bus.smp_addr !== 10'd0) begin n_fail++; $display("FAIL single_first_read: busy=%0b rd_en=%0b addr=%0d want 1 1 0", busy, bus.smp_rd_en, bus.smp_addr); end
        n_checks++; if (bus.fft_win !== 1'b1 || bus.fft_n_need !== 8'd128 || bus.fft_scale !== 4'h5) begin n_fail++; $display("FAIL single_ctrl: win=%0b n_need=%0d scale=%0d want 1 128 5", bus.fft_win, bus.fft_n_need, bus.fft_scale); end
        wait_done(3000, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: done not seen within budget"); end
        n_checks++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_status: done=%0b err=%0b busy=%0b want 1 0 0", done, err, busy); end
        n_checks++; if (rd_addr_q.size() !== 256) begin n_fail++; $display("FAIL single_rd_count: got %0d want 256", rd_addr_q.size()); end
        for (int k = 0; k < rd_addr_q.size() && k < 256; k++) begin
            n_checks++;
            if (rd_addr_q[k] !== 10'(k)) begin n_fail++; $display("FAIL single_addr[%0d]: got %0d want %0d", k, rd_addr_q[k], k); break; end
        end
        n_checks++; if (fed_q.size() !== 256) begin n_fail++; $display("FAIL single_fed_count: got %0d want 256", fed_q.size()); end
        for (int k = 0; k < fed_q.size() && k < 256; k++) begin
            n_checks++;
            if (fed_q[k] !== ram_val(k)) begin n_fail++; $display("FAIL single_fed[%0d]: got %0h want %0h", k, fed_q[k], ram_val(k)); break; end
        end
        n_checks++; if (out_q.size() !== 128 || out_last_cnt !== 1) begin n_fail++; $display("FAIL single_out: beats=%0d lasts=%0d want 128 1", out_q.size(), out_last_cnt); end
        for (int k = 0; k < out_q.size() && k < 128; k++) begin
            n_checks++;
            if (out_q[k] !== 32'hE000_0000 + 32'(k)) begin n_fail++; $display("FAIL single_out[%0d]: got %0h want %0h", k, out_q[k], 32'hE000_0000 + 32'(k)); break; end
        end
    endtask

    task automatic test_wrap_multi_frame;
        bit to;
        logic [9:0] ea;
        emit_n = 128;
        do_start(10'd1000, 10'd128, 8'd3, 8'd128, 1'b0, 4'h0);
        wait_done(6000, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout: done not seen within budget"); end
        n_checks++; if (err !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL wrap_status: err=%0b done=%0b want 0 1", err, done); end
        n_checks++; if (rd_addr_q.size() !== 768 || fed_q.size() !== 768) begin n_fail++; $display("FAIL wrap_count: reads=%0d fed=%0d want 768 768", rd_addr_q.size(), fed_q.size()); end
        if (rd_addr_q.size() == 768) begin
            n_checks++; if (rd_addr_q[0] !== 10'd1000 || rd_addr_q[256] !== 10'd104 || rd_addr_q[512] !== 10'd232) begin n_fail++; $display("FAIL wrap_frame_starts: got %0d %0d %0d want 1000 104 232", rd_addr_q[0], rd_addr_q[256], rd_addr_q[512]); end
            n_checks++; if (rd_addr_q[23] !== 10'd1023 || rd_addr_q[24] !== 10'd0) begin n_fail++; $display("FAIL wrap_seam: got %0d %0d want 1023 0", rd_addr_q[23], rd_addr_q[24]); end
        end
        for (int k = 0; k < rd_addr_q.size() && k < 768; k++) begin
            ea = 10'((1000 + 128 * (k / 256) + (k % 256)) % 1024);
            n_checks++;
            if (rd_addr_q[k] !== ea || rd_fidx_q[k] !== 8'(k / 256)) begin n_fail++; $display("FAIL wrap_read[%0d]: addr=%0d idx=%0d want %0d %0d", k, rd_addr_q[k], rd_fidx_q[k], ea, k / 256); break; end
        end
        for (int k = 0; k < fed_q.size() && k < 768; k++) begin
            ea = 10'((1000 + 128 * (k / 256) + (k % 256)) % 1024);
            n_checks++;
            if (fed_q[k] !== ram_val(int'(ea))) begin n_fail++; $display("FAIL wrap_fed[%0d]: got %0h want %0h", k, fed_q[k], ram_val(int'(ea))); break; end
        end
        n_checks++; if (out_q.size() !== 384 || out_last_cnt !== 3) begin n_fail++; $display("FAIL wrap_out: beats=%0d lasts=%0d want 384 3", out_q.size(), out_last_cnt); end
    endtask

    task automatic test_random_stall;
        bit to;
        logic [9:0] ea;
        emit_n = 128;
        rnd_mode = 1'b1;
        do_start(10'd300, 10'd64, 8'd2, 8'd128, 1'b0, 4'h3);
        wait_done(20000, to);
        rnd_mode = 1'b0;
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand_timeout: done not seen within budget"); end
        n_checks++; if (fed_q.size() !== 512) begin n_fail++; $display("FAIL rand_fed_count: got %0d want 512", fed_q.size()); end
        for (int k = 0; k < fed_q.size() && k < 512; k++) begin
            ea = 10'((300 + 64 * (k / 256) + (k % 256)) % 1024);
            n_checks++;
            if (fed_q[k] !== ram_val(int'(ea))) begin n_fail++; $display("FAIL rand_fed[%0d]: got %0h want %0h", k, fed_q[k], ram_val(int'(ea))); break; end
        end
        n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d violations want 0", stall_viol); end
        n_checks++; if (out_q.size() !== 256 || out_last_cnt !== 2) begin n_fail++; $display("FAIL rand_out: beats=%0d lasts=%0d want 256 2", out_q.size(), out_last_cnt); end
        for (int k = 0; k < out_q.size() && k < 256; k++) begin
            n_checks++;
            if (out_q[k] !== 32'hE000_0000 + 32'(k)) begin n_fail++; $display("FAIL rand_out[%0d]: got %0h want %0h", k, out_q[k], 32'hE000_0000 + 32'(k)); break; end
        end
        n_checks++; if (err !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL rand_status: err=%0b done=%0b want 0 1", err, done); end
    endtask

    task automatic test_short_frame_err;
        bit to;
        int i;
        emit_n = 101;
        do_start(10'd0, 10'd256, 8'd2, 8'd128, 1'b0, 4'h0);
        for (i = 0; i < 2000 && err !== 1'b1; i++) @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL short_err_seen: got %0b want 1", err); end
        n_checks++; if (busy !== 1'b1 || frame_idx !== 8'd0 || done !== 1'b0) begin n_fail++; $display("FAIL short_continue: busy=%0b idx=%0d done=%0b want 1 0 0", busy, frame_idx, done); end
        wait_done(3000, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL short_timeout: done not seen within budget"); end
        n_checks++; if (err !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL short_status: err=%0b done=%0b want 1 1", err, done); end
        n_checks++; if (fed_q.size() !== 512 || out_q.size() !== 202) begin n_fail++; $display("FAIL short_counts: fed=%0d out=%0d want 512 202", fed_q.size(), out_q.size()); end
        emit_n = 128;
    endtask

    task automatic test_abort_restart;
        bit to;
        int i;
        do_start(10'd500, 10'd256, 8'd1, 8'd128, 1'b0, 4'h0);
        for (i = 0; i < 1000 && fed_q.size() < 77; i++) @(negedge clk);
        n_checks++; if (fed_q.size() !== 77) begin n_fail++; $display("FAIL abort_reach77: got %0d want 77", fed_q.size()); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy=%0b done=%0b want 0 0", busy, done); end
        n_checks++; if (bus.fft_valid !== 1'b0 || bus.smp_rd_en !== 1'b0) begin n_fail++; $display("FAIL abort_flush: fft_valid=%0b rd_en=%0b want 0 0", bus.fft_valid, bus.smp_rd_en); end
        repeat (3) @(negedge clk);
        do_start(10'd500, 10'd256, 8'd1, 8'd128, 1'b0, 4'h0);
        n_checks++; if (bus.smp_addr !== 10'd500 || bus.fft_valid !== 1'b0) begin n_fail++; $display("FAIL abort_restart: addr=%0d fft_valid=%0b want 500 0", bus.smp_addr, bus.fft_valid); end
        wait_done(3000, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL abort_timeout: done not seen within budget"); end
        n_checks++; if (fed_q.size() !== 256 || out_q.size() !== 128 || err !== 1'b0) begin n_fail++; $display("FAIL abort_rerun: fed=%0d out=%0d err=%0b want 256 128 0", fed_q.size(), out_q.size(), err); end
        for (int k = 0; k < fed_q.size() && k < 256; k++) begin
            n_checks++;
            if (fed_q[k] !== ram_val((500 + k) % 1024)) begin n_fail++; $display("FAIL abort_fed[%0d]: got %0h want %0h", k, fed_q[k], ram_val((500 + k) % 1024)); break; end
        end
    endtask

    task automatic test_reset_mid_drain;
        bit to;
        int i;
        fix_out_ready = 1'b0;
        do_start(10'd0, 10'd256, 8'd1, 8'd128, 1'b1, 4'h7);
        for (i = 0; i < 1000 && fed_q.size() < 256; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || fed_q.size() !== 256) begin n_fail++; $display("FAIL drain_reached: busy=%0b fed=%0d want 1 256", busy, fed_q.size()); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || frame_idx !== 8'd0) begin n_fail++; $display("FAIL rst_async_status: busy=%0b done=%0b err=%0b idx=%0d want 0", busy, done, err, frame_idx); end
        n_checks++; if (bus.fft_n_need !== 8'd0 || bus.fft_win !== 1'b0 || bus.out_valid !== 1'b0 || bus.res_ready !== 1'b0 || bus.smp_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_async_outputs: n_need=%0d win=%0b out_valid=%0b res_ready=%0b rd_en=%0b want 0", bus.fft_n_need, bus.fft_win, bus.out_valid, bus.res_ready, bus.smp_rd_en); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fix_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_start(10'd0, 10'd256, 8'd1, 8'd128, 1'b0, 4'h0);
        wait_done(3000, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rst_rerun_timeout: done not seen within budget"); end
        n_checks++; if (fed_q.size() !== 256 || out_q.size() !== 128 || err !== 1'b0) begin n_fail++; $display("FAIL rst_rerun: fed=%0d out=%0d err=%0b want 256 128 0", fed_q.size(), out_q.size(), err); end
        for (int k = 0; k < fed_q.size() && k < 256; k++) begin
            n_checks++;
            if (fed_q[k] !== ram_val(k)) begin n_fail++; $display("FAIL rst_rerun_fed[%0d]: got %0h want %0h", k, fed_q[k], ram_val(k)); break; end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_wrap_multi_frame();
        test_random_stall();
        test_short_frame_err();
        test_abort_restart();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
